// File: rtl/frame_aligned_crossbar_pkg.sv
// Shared types and helpers for the frame-aligned crossbar.
package switch_pkg;

   // Width of one per-output FSM state field on the debug bus.
   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      IDLE    = 2'd0,
      FWD     = 2'd1,
      DISCARD = 2'd2
   } xbar_state_t;

   typedef int unsigned port_idx_t;

   // Legacy pair swap: o^1, except the unpaired last port of an odd-sized
   // crossbar, which loops back to itself.
   function automatic port_idx_t default_src(input port_idx_t o, input port_idx_t n);
      if ((n[0] == 1'b1) && (o == n - 1)) return o;
      return o ^ port_idx_t'(1);
   endfunction

endpackage

// File: rtl/frame_aligned_crossbar_if.sv
// Bus bundle of the crossbar: receive streams, map configuration, transmit
// streams, frame counters and per-output FSM state.
//
// Handshake: cfg_valid is a single-cycle strobe with no ready/backpressure;
// every cycle it is high, the whole cfg_sel word is taken. rx_ctrl/tx_ctrl
// qualify the byte on the same port in the same cycle; there is no ready,
// the stream is never stalled.
interface frame_aligned_crossbar_if
   import switch_pkg::*;
#(
   parameter int N_PORTS = 4,
   parameter int DATA_W  = 8,
   parameter int CNT_W   = 16,
   parameter int SEL_W   = $clog2(N_PORTS)
);
   logic [N_PORTS-1:0]         link_sync;
   logic [N_PORTS*DATA_W-1:0]  rx_data;
   logic [N_PORTS-1:0]         rx_ctrl;
   logic [N_PORTS*SEL_W-1:0]   cfg_sel;
   logic                       cfg_valid;
   logic [N_PORTS-1:0]         cfg_pending;
   logic [N_PORTS*DATA_W-1:0]  tx_data;
   logic [N_PORTS-1:0]         tx_ctrl;
   logic [N_PORTS*CNT_W-1:0]   tx_frames;
   logic [N_PORTS*STATE_W-1:0] dbg_state;

   // Traffic and configuration source side.
   modport master (
      output link_sync, rx_data, rx_ctrl, cfg_sel, cfg_valid,
      input  cfg_pending, tx_data, tx_ctrl, tx_frames, dbg_state
   );

   // Crossbar side.
   modport slave (
      input  link_sync, rx_data, rx_ctrl, cfg_sel, cfg_valid,
      output cfg_pending, tx_data, tx_ctrl, tx_frames, dbg_state
   );
endinterface

// File: rtl/frame_aligned_crossbar_out_port.sv
// One crossbar output: source selection with frame-boundary remap, framing
// FSM, saturating frame counter and registered transmit byte.
module xbar_out_port
   import switch_pkg::*;
#(
   parameter int N_PORTS = 4,
   parameter int DATA_W  = 8,
   parameter int CNT_W   = 16,
   parameter int SEL_W   = $clog2(N_PORTS),
   parameter int PORT    = 0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_PORTS-1:0]        link_sync_i,
   input  logic [N_PORTS*DATA_W-1:0] rx_data_i,
   input  logic [N_PORTS-1:0]        rx_ctrl_i,
   input  logic [SEL_W-1:0]          cfg_sel_i,
   input  logic                      cfg_valid_i,
   output logic                      pending_o,
   output logic [DATA_W-1:0]         tx_data_o,
   output logic                      tx_ctrl_o,
   output logic [CNT_W-1:0]          frames_o,
   output xbar_state_t               state_o
);

   localparam logic [SEL_W-1:0] RESET_SEL = SEL_W'(default_src(port_idx_t'(PORT), port_idx_t'(N_PORTS)));

   xbar_state_t       state_q, state_d;
   logic [SEL_W-1:0]  active_sel_q, active_sel_d;
   logic [SEL_W-1:0]  pending_sel_q, pending_sel_d;
   logic              pending_flag_q, pending_flag_d;
   logic              fresh_q, fresh_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] tx_data_q, tx_data_d;
   logic              tx_ctrl_q, tx_ctrl_d;

   logic [DATA_W-1:0] rx_arr [N_PORTS];
   logic              sel_ok;
   logic              up;
   logic              c;
   logic              apply;

   // Unpack the flat receive bus so the active source can be indexed directly.
   always_comb begin
      for (int p = 0; p < N_PORTS; p++) begin
         rx_arr[p] = rx_data_i[p*DATA_W +: DATA_W];
      end
   end

   // Next-state logic: config capture, framing FSM, counter and output byte.
   always_comb begin
      state_d        = state_q;
      active_sel_d   = active_sel_q;
      pending_sel_d  = pending_sel_q;
      pending_flag_d = pending_flag_q;
      fresh_d        = 1'b0;
      cnt_d          = cnt_q;
      tx_data_d      = '0;
      tx_ctrl_d      = 1'b0;

      sel_ok = (int'(cfg_sel_i) < N_PORTS);
      up     = link_sync_i[active_sel_q] & link_sync_i[PORT];
      c      = rx_ctrl_i[active_sel_q];
      // A queued map is only taken between frames, and never in a cycle that
      // is itself delivering a newer map.
      apply  = (state_q == IDLE) && pending_flag_q && !cfg_valid_i;

      // Out-of-range requests leave this output's queued map untouched.
      if (cfg_valid_i && sel_ok) begin
         pending_sel_d  = cfg_sel_i;
         pending_flag_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (apply) begin
               active_sel_d   = pending_sel_q;
               pending_flag_d = 1'b0;
               fresh_d        = 1'b1;
            end else if (c) begin
               // A source already busy right after a remap, or a frame that
               // starts while the link is down, is skipped whole so that an
               // output never begins mid-frame.
               if (up && !fresh_q) state_d = FWD;
               else                state_d = DISCARD;
            end
         end
         FWD: begin
            if (!c) begin
               state_d = IDLE;
               if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
            end else if (!up) begin
               state_d = DISCARD;
            end
         end
         DISCARD: begin
            if (!c) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // The byte that opens or continues a frame is registered on the same
      // edge, giving one cycle of latency with no lost start byte.
      if (state_d == FWD) begin
         tx_data_d = rx_arr[active_sel_q];
         tx_ctrl_d = 1'b1;
      end
   end

   // State and output registers; reset restores the pair-swap map.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= IDLE;
         active_sel_q   <= RESET_SEL;
         pending_sel_q  <= '0;
         pending_flag_q <= 1'b0;
         fresh_q        <= 1'b0;
         cnt_q          <= '0;
         tx_data_q      <= '0;
         tx_ctrl_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         active_sel_q   <= active_sel_d;
         pending_sel_q  <= pending_sel_d;
         pending_flag_q <= pending_flag_d;
         fresh_q        <= fresh_d;
         cnt_q          <= cnt_d;
         tx_data_q      <= tx_data_d;
         tx_ctrl_q      <= tx_ctrl_d;
      end
   end

   assign pending_o = pending_flag_q;
   assign tx_data_o = tx_data_q;
   assign tx_ctrl_o = tx_ctrl_q;
   assign frames_o  = cnt_q;
   assign state_o   = state_q;

endmodule

// File: rtl/frame_aligned_crossbar.sv
// N-port registered byte-stream crossbar with runtime map applied only at
// frame boundaries. One xbar_out_port per output; config fans out to all.
module frame_aligned_crossbar
   import switch_pkg::*;
#(
   parameter int N_PORTS = 4,
   parameter int DATA_W  = 8,
   parameter int CNT_W   = 16,
   parameter int SEL_W   = $clog2(N_PORTS)
) (
   input logic                      clk,
   input logic                      reset,
   frame_aligned_crossbar_if.slave  bus
);

   logic [N_PORTS-1:0]         pending;
   logic [N_PORTS*DATA_W-1:0]  tx_data;
   logic [N_PORTS-1:0]         tx_ctrl;
   logic [N_PORTS*CNT_W-1:0]   tx_frames;
   logic [N_PORTS*STATE_W-1:0] dbg_state;

   for (genvar o = 0; o < N_PORTS; o++) begin : g_out
      xbar_state_t st;

      xbar_out_port #(
         .N_PORTS (N_PORTS),
         .DATA_W  (DATA_W),
         .CNT_W   (CNT_W),
         .SEL_W   (SEL_W),
         .PORT    (o)
      ) u_port (
         .clk         (clk),
         .reset       (reset),
         .link_sync_i (bus.link_sync),
         .rx_data_i   (bus.rx_data),
         .rx_ctrl_i   (bus.rx_ctrl),
         .cfg_sel_i   (bus.cfg_sel[o*SEL_W +: SEL_W]),
         .cfg_valid_i (bus.cfg_valid),
         .pending_o   (pending[o]),
         .tx_data_o   (tx_data[o*DATA_W +: DATA_W]),
         .tx_ctrl_o   (tx_ctrl[o]),
         .frames_o    (tx_frames[o*CNT_W +: CNT_W]),
         .state_o     (st)
      );

      assign dbg_state[o*STATE_W +: STATE_W] = st;
   end

   assign bus.cfg_pending = pending;
   assign bus.tx_data     = tx_data;
   assign bus.tx_ctrl     = tx_ctrl;
   assign bus.tx_frames   = tx_frames;
   assign bus.dbg_state   = dbg_state;

endmodule

// File: tb/tb_frame_aligned_crossbar.sv
// Directed bench for frame_aligned_crossbar: a 4-port instance for the main
// forwarding/remap/link-loss/fan-out cases and a 3-port, 2-bit-counter
// instance for odd-port default map, out-of-range config, saturation and
// asynchronous reset.
module tb_frame_aligned_crossbar;

   logic clk;
   logic rst_n;

   int n_tests = 0;
   int n_fail  = 0;

   frame_aligned_crossbar_if #(.N_PORTS(4), .DATA_W(8), .CNT_W(16)) b4 ();
   frame_aligned_crossbar_if #(.N_PORTS(3), .DATA_W(8), .CNT_W(2))  b3 ();

   frame_aligned_crossbar #(.N_PORTS(4), .DATA_W(8), .CNT_W(16)) dut4 (
      .clk   (clk),
      .reset (rst_n),
      .bus   (b4)
   );

   frame_aligned_crossbar #(.N_PORTS(3), .DATA_W(8), .CNT_W(2)) dut3 (
      .clk   (clk),
      .reset (rst_n),
      .bus   (b3)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: run did not complete, got timeout required finish");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   logic [7:0] exp_q [$];
   logic [3:0] watch;
   int         cap_cnt [4];
   int         cap3 [3];
   int         pend_cnt;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Observe the 4-port outputs just after an edge.
   task automatic mon4();
      logic [7:0] want;
      for (int o = 0; o < 4; o++) if (b4.tx_ctrl[o]) cap_cnt[o]++;
      if (b4.cfg_pending[0]) pend_cnt++;
      if ((b4.tx_ctrl & watch) != 4'b0) begin
         check("sb_avail", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            want = exp_q.pop_front();
            for (int o = 0; o < 4; o++) begin
               if (watch[o]) begin
                  check("tx_ctrl_w", b4.tx_ctrl[o], 1);
                  check("tx_data_w", b4.tx_data[o*8 +: 8], want);
               end
            end
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle4(input int n);
      watch = 4'b0;
      for (int i = 0; i < n; i++) begin
         tick();
         mon4();
      end
   endtask

   task automatic cfg4(input logic [7:0] sel);
      b4.cfg_sel   = sel;
      b4.cfg_valid = 1'b1;
      tick();
      mon4();
      b4.cfg_valid = 1'b0;
   endtask

   // Drive a len-byte frame on src, optionally strobing cfg at byte cfg_at and
   // toggling link_sync[src] at byte lnk_at. The first rec_len bytes are the
   // ones expected on every watched output.
   task automatic frame4(input int src, input int len, input int base, input logic [3:0] wmask,
                         input int cfg_at, input int lnk_at, input int rec_len);
      watch    = wmask;
      pend_cnt = 0;
      for (int o = 0; o < 4; o++) cap_cnt[o] = 0;
      for (int i = 0; i < len; i++) begin
         b4.rx_ctrl[src]          = 1'b1;
         b4.rx_data[src*8 +: 8]   = 8'(base + i);
         b4.cfg_valid             = (i == cfg_at);
         if (i == lnk_at) b4.link_sync[src] = ~b4.link_sync[src];
         if (i < rec_len) exp_q.push_back(8'(base + i));
         tick();
         mon4();
      end
      b4.rx_ctrl[src]        = 1'b0;
      b4.rx_data[src*8 +: 8] = 8'h00;
      b4.cfg_valid           = 1'b0;
      tick();
      mon4();
      check("sb_empty", exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic chk_cap4(input string tag, input int a, input int b, input int c, input int d);
      check({tag, "_o0"}, cap_cnt[0], a);
      check({tag, "_o1"}, cap_cnt[1], b);
      check({tag, "_o2"}, cap_cnt[2], c);
      check({tag, "_o3"}, cap_cnt[3], d);
   endtask

   task automatic frame3(input int src, input int len);
      for (int o = 0; o < 3; o++) cap3[o] = 0;
      for (int i = 0; i <= len; i++) begin
         b3.rx_ctrl[src]        = (i < len);
         b3.rx_data[src*8 +: 8] = (i < len) ? 8'(8'h30 + i) : 8'h00;
         tick();
         for (int o = 0; o < 3; o++) begin
            if (b3.tx_ctrl[o]) begin
               cap3[o]++;
               check("tx3_data", b3.tx_data[o*8 +: 8], 8'(8'h30 + i));
            end
         end
      end
   endtask

   task automatic chk_cap3(input string tag, input int a, input int b, input int c);
      check({tag, "_o0"}, cap3[0], a);
      check({tag, "_o1"}, cap3[1], b);
      check({tag, "_o2"}, cap3[2], c);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n        = 1'b0;
      watch        = 4'b0;
      b4.link_sync = '0;
      b4.rx_data   = '0;
      b4.rx_ctrl   = '0;
      b4.cfg_sel   = '0;
      b4.cfg_valid = 1'b0;
      b3.link_sync = '0;
      b3.rx_data   = '0;
      b3.rx_ctrl   = '0;
      b3.cfg_sel   = '0;
      b3.cfg_valid = 1'b0;
      for (int i = 0; i < 3; i++) tick();

      check("rst_ctrl4",   b4.tx_ctrl,     0);
      check("rst_data4",   b4.tx_data,     0);
      check("rst_frames4", b4.tx_frames,   0);
      check("rst_pend4",   b4.cfg_pending, 0);
      check("rst_state4",  b4.dbg_state,   0);
      check("rst_ctrl3",   b3.tx_ctrl,     0);
      check("rst_frames3", b3.tx_frames,   0);

      b4.link_sync = 4'hF;
      b3.link_sync = 3'h7;
      rst_n = 1'b1;
      idle4(2);

      // 1: port 0 -> output 1 via pair swap, 64 bytes
      frame4(0, 64, 0, 4'b0010, -1, -1, 64);
      chk_cap4("t1_cap", 0, 64, 0, 0);
      check("t1_frames", b4.tx_frames, 64'h0000_0000_0001_0000);

      // 2: remap {3,2,1,0} mid-frame on port 1 -> output 0
      b4.cfg_sel = 8'h1B;
      frame4(1, 16, 8'h40, 4'b0001, 8, -1, 16);
      check("t2_pend_cycles", pend_cnt, 9);
      chk_cap4("t2_cap", 16, 0, 0, 0);
      check("t2_frames", b4.tx_frames, 64'h0000_0000_0001_0001);
      idle4(2);
      check("t2_pend_clr", b4.cfg_pending, 0);
      check("t2_state", b4.dbg_state, 0);
      frame4(3, 12, 8'h80, 4'b0001, -1, -1, 12);
      chk_cap4("t2b_cap", 12, 0, 0, 0);
      check("t2b_frames", b4.tx_frames, 64'h0000_0000_0001_0002);

      // 3: output 1 remapped onto port 0 while port 0 is mid-frame
      b4.cfg_sel = 8'h13;
      frame4(0, 20, 8'hA0, 4'b1000, 5, -1, 20);
      chk_cap4("t3_cap", 0, 0, 0, 20);
      check("t3_frames", b4.tx_frames, 64'h0001_0000_0001_0002);
      idle4(2);
      check("t3_pend_clr", b4.cfg_pending, 0);
      frame4(0, 8, 8'hC0, 4'b1010, -1, -1, 8);
      chk_cap4("t3b_cap", 0, 8, 0, 8);
      check("t3b_frames", b4.tx_frames, 64'h0002_0000_0002_0002);

      // 4: link 0 lost at byte 10, restored mid-frame, then a clean frame
      frame4(0, 20, 8'h20, 4'b0010, -1, 10, 10);
      chk_cap4("t4_cap", 0, 10, 0, 10);
      check("t4_frames", b4.tx_frames, 64'h0002_0000_0002_0002);
      frame4(0, 10, 8'h50, 4'b0000, -1, 4, 0);
      chk_cap4("t4b_cap", 0, 0, 0, 0);
      check("t4b_frames", b4.tx_frames, 64'h0002_0000_0002_0002);
      frame4(0, 6, 8'h60, 4'b1010, -1, -1, 6);
      chk_cap4("t4c_cap", 0, 6, 0, 6);
      check("t4c_frames", b4.tx_frames, 64'h0003_0000_0003_0002);

      // 5: fan-out of port 2 to every output
      cfg4(8'hAA);
      check("t5_pend_set", b4.cfg_pending, 4'hF);
      idle4(2);
      check("t5_pend_clr", b4.cfg_pending, 0);
      frame4(2, 20, 8'h10, 4'hF, -1, -1, 20);
      chk_cap4("t5_cap", 20, 20, 20, 20);
      check("t5_frames", b4.tx_frames, 64'h0004_0001_0004_0003);

      // 5b: 3-port instance, odd last port maps to itself
      frame3(2, 4);
      chk_cap3("t5c_cap", 0, 0, 4);
      check("t5c_frames", b3.tx_frames, 6'h10);

      // 5c: out-of-range index for output 0 is ignored
      b3.cfg_sel   = 6'h2B;
      b3.cfg_valid = 1'b1;
      tick();
      b3.cfg_valid = 1'b0;
      check("t5d_pend", b3.cfg_pending, 3'b110);
      tick();
      tick();
      check("t5d_pend_clr", b3.cfg_pending, 0);
      frame3(2, 5);
      chk_cap3("t5d_cap", 0, 5, 5);
      check("t5d_frames", b3.tx_frames, 6'h24);

      // 6: 2-bit counters saturate at 3
      for (int k = 0; k < 4; k++) frame3(2, 3);
      check("t6_sat", b3.tx_frames, 6'h3C);

      // 6b: async reset mid-frame with a map pending
      b3.cfg_sel = 6'h12;
      for (int i = 0; i < 3; i++) begin
         b3.rx_ctrl[2]    = 1'b1;
         b3.rx_data[23:16] = 8'(8'h70 + i);
         b3.cfg_valid     = (i == 1);
         tick();
         if (i == 1) check("t6_pend_mid", b3.cfg_pending, 3'b111);
      end
      b3.cfg_valid = 1'b0;
      check("t6_fwd_mid", b3.tx_ctrl, 3'b110);
      #3 rst_n = 1'b0;
      #1;
      check("t6_rst_ctrl3",   b3.tx_ctrl,     0);
      check("t6_rst_data3",   b3.tx_data,     0);
      check("t6_rst_frames3", b3.tx_frames,   0);
      check("t6_rst_pend3",   b3.cfg_pending, 0);
      check("t6_rst_state3",  b3.dbg_state,   0);
      check("t6_rst_frames4", b4.tx_frames,   0);
      b3.rx_ctrl = '0;
      b3.rx_data = '0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      frame3(0, 3);
      chk_cap3("t6_swap0", 0, 3, 0);
      frame3(2, 3);
      chk_cap3("t6_swap2", 0, 0, 3);
      check("t6_frames_after", b3.tx_frames, 6'h14);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/frame_aligned_crossbar.md
# frame_aligned_crossbar

Parametrised N-port registered crossbar that forwards GMII-style byte streams (data plus a ctrl/valid strobe per port) from any source port to any output port under a runtime-programmable map. It replaces the fixed port-0/port-1 swap path in `switchcore` and sits between the per-port receive logic and the transmit pins. Map changes are applied only at frame boundaries. Links without `link_sync` are gated. Each output keeps a saturating count of forwarded frames.

## Interface
Parameters:
- `N_PORTS`, 4: number of ports; must be ≥ 2.
- `DATA_W`, 8: data bits per port.
- `CNT_W`, 16: width of each per-output frame counter.
- `SEL_W`, `$clog2(N_PORTS)`: derived; width of one source index.

Ports:
- `clk`  in  1: single clock. All logic is in this domain.
- `reset`  in  1: asynchronous, active-low reset.
- `link_sync`  in  N_PORTS: 1 means a peer is present on that port.
- `rx_data`  in  N_PORTS*DATA_W: port p occupies bits [p*DATA_W +: DATA_W].
- `rx_ctrl`  in  N_PORTS: 1 means a frame byte is valid on that port.
- `cfg_sel`  in  N_PORTS*SEL_W: requested source for each output o, in field [o*SEL_W +: SEL_W].
- `cfg_valid`  in  1: one-cycle strobe that captures all of `cfg_sel` as pending.
- `cfg_pending`  out  N_PORTS: 1 while output o still holds an unapplied selection.
- `tx_data`  out  N_PORTS*DATA_W: forwarded data, same packing as `rx_data`.
- `tx_ctrl`  out  N_PORTS: forwarded ctrl.
- `tx_frames`  out  N_PORTS*CNT_W: count of completed frames on output o, in field [o*CNT_W +: CNT_W].

## Operation
Per-output state, for each output o:
- `active_sel`: source currently routed to o.
- `pending_sel` and `pending_flag`: the next selection, and whether one is waiting.
- FSM with states IDLE, FWD and DISCARD.

Reset values:
- `active_sel[o]` = o^1, the legacy pair swap. When N_PORTS is odd, the last port maps to itself.
- `pending_flag` = 0.
- FSM state = IDLE.
- Counters = 0.
- `tx_data` = 0 and `tx_ctrl` = 0.

Configuration:
- `cfg_valid`=1 loads `pending_sel[o]` from `cfg_sel` and sets `pending_flag[o]` for every o.
- If a selection is already pending, the new one overwrites it. Only the last selection is kept.
- An out-of-range index (≥ N_PORTS) is ignored for that output. That output keeps its existing pending state.

Definitions, with s = `active_sel[o]`:
- `up` = `link_sync[s]` & `link_sync[o]`.
- `c` = `rx_ctrl[s]`.

FSM transitions:
- IDLE → FWD when `up` & `c`.
- IDLE: if `pending_flag` is set, load `active_sel` from `pending_sel` and clear `pending_flag`. This happens instead of the FWD check that cycle.
- FWD: forward the source. On !`c`, go to IDLE and increment `tx_frames[o]`, saturating at all-ones.
- FWD → DISCARD when !`up` while `c`=1. The frame is truncated and not counted.
- DISCARD → IDLE on !`c`.

Loading a new `active_sel` in IDLE:
- If the new source's `rx_ctrl` is already 1 on the next cycle, the output goes IDLE → DISCARD instead of FWD.
- The output never starts mid-frame.

Output values:
- In FWD with `up`, the registered output is `tx_data[o]` = `rx_data[s]` and `tx_ctrl[o]` = 1.
- In every other case, the registered output is 0 / 0.

Fan-out: several outputs may select the same source. Each output's FSM runs independently.

## Timing
- Latency is exactly 1 cycle: a byte on `rx_*` at edge t appears on `tx_*` after edge t+1.
- The first byte of a frame is forwarded with no loss of the start-of-frame byte.
- A config strobe at edge t sets `cfg_pending[o]` after edge t+1.
- A pending selection is applied on the first edge where the FSM is IDLE, with `cfg_valid` absent that cycle.
- The new source is visible on `tx` at the earliest 2 cycles after it is applied.
- The end of a frame and a pending selection in the same cycle: the frame closes (FWD → IDLE) first. The selection is applied on the following edge.
- Link loss mid-frame: `tx_ctrl` falls after the next edge. Nothing further is forwarded until the source ctrl goes low and then rises again.
- Asserting `reset` mid-frame clears everything immediately, asynchronously. This includes discarding the pending map.

## Structure
- `switch_pkg` holds:
  - `xbar_state_t` enum (IDLE / FWD / DISCARD),
  - `port_idx_t`,
  - a `default_src(o, n)` function that returns o^1, or o for the odd last port.
- One sub-module, `xbar_out_port`: one instance per output. It contains the FSM, the pending register, the counter and the output register, and takes the full `rx` bus plus `link_sync`.
- The top level is a generate loop plus config fan-out.

## Test plan
1. Reset, links all up, frame of 64 bytes (values 0x00..0x3F) on port 0 → output 1 shows the same bytes with 1-cycle delay, ctrl high for exactly 64 cycles, `tx_frames[1]`=1.
2. `cfg_valid` with map {3,2,1,0} while port 1's frame is mid-way to output 0 → output 0 finishes the old frame intact. `cfg_pending[0]` stays 1 until the frame ends. The next frame on port 3 is forwarded to output 0.
3. Apply a remap when the new source is already mid-frame → the output stays ctrl=0 for the remainder of that frame, then forwards the next full frame. The counter increments only once.
4. Drop `link_sync[0]` at byte 10 of a frame → `tx_ctrl[1]` falls one cycle later, `tx_frames[1]` is unchanged, and no bytes are forwarded until a new frame starts after the link returns.
5. Fan-out: map all outputs to port 2, send a 20-byte frame → all four outputs are identical and every counter is 1. An out-of-range `cfg_sel` (when N_PORTS=3, with index 3) leaves that output unchanged.
6. Preset the counter to near saturation (`CNT_W`=2, 5 frames) → `tx_frames` reads 3. Then assert `reset` mid-frame → all outputs are 0 and the map returns to the pair swap.
